// File: rtl/colour_frame_stats.sv
// Per-frame dominant-colour pixel counter for a sop/eop pixel stream.
// Classifies each pixel inside a runtime ROI and latches per-channel counts at frame end.
module colour_frame_stats #(
    parameter int PIX_W   = 12,
    parameter int COMP_W  = 4,
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240,
    parameter int CNT_W   = 17,
    localparam int NUM_CH = PIX_W / COMP_W,
    localparam int XW     = $clog2(IMG_W),
    localparam int YW     = $clog2(IMG_H),
    localparam int MW     = $clog2(NUM_CH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pix_valid,
    input  logic                    pix_sop,
    input  logic                    pix_eop,
    input  logic [PIX_W-1:0]        pix_data,
    input  logic [COMP_W-1:0]       margin,
    input  logic [COMP_W-1:0]       min_level,
    input  logic [XW-1:0]           roi_x0,
    input  logic [XW-1:0]           roi_x1,
    input  logic [YW-1:0]           roi_y0,
    input  logic [YW-1:0]           roi_y1,
    output logic [NUM_CH*CNT_W-1:0] counts_out,
    output logic [MW-1:0]           max_ch,
    output logic                    stats_valid,
    output logic                    frame_err
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int IW   = $clog2(NPIX + 1);
    localparam logic [IW-1:0]    LAST_IDX = IW'(NPIX - 1);
    localparam logic [IW-1:0]    IDX_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [XW-1:0]    X_LAST   = XW'(IMG_W - 1);
    localparam logic [YW-1:0]    Y_LAST   = YW'(IMG_H - 1);

    generate
        if (NUM_CH * COMP_W != PIX_W) begin : g_bad_width
            $error("PIX_W must be an exact multiple of COMP_W");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, LATCH = 2'd2} state_t;
    state_t state, state_nxt;

    logic              beat_sop, beat_eop, frame_start, take, restart_err, eop_err, eop_err_q;
    logic [XW-1:0]     x_q, cur_x, x_nxt, rx0_q, rx1_q, rx0, rx1;
    logic [YW-1:0]     y_q, cur_y, y_nxt, ry0_q, ry1_q, ry0, ry1;
    logic [IW-1:0]     idx_q, cur_idx, idx_nxt;
    logic              in_roi;
    logic [COMP_W-1:0] comp [NUM_CH];
    logic [NUM_CH-1:0] hit, hit_q;
    logic [CNT_W-1:0]  acc [NUM_CH];
    logic [CNT_W-1:0]  acc_nxt [NUM_CH];
    logic [CNT_W-1:0]  best_cnt;
    logic [MW-1:0]     best_ch;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_start) state_nxt = beat_eop ? LATCH : COUNT;
            COUNT:   if (beat_eop) state_nxt = LATCH;
            LATCH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A sop during LATCH is dropped: the frame window is closed for that cycle.
    always_comb begin
        beat_sop    = pix_valid & pix_sop;
        beat_eop    = pix_valid & pix_eop;
        frame_start = beat_sop && (state != LATCH);
        take        = frame_start || (pix_valid && (state == COUNT));
        restart_err = beat_sop && (state == COUNT);
    end

    always_comb begin
        cur_x   = frame_start ? '0 : x_q;
        cur_y   = frame_start ? '0 : y_q;
        cur_idx = frame_start ? '0 : idx_q;
        rx0     = frame_start ? roi_x0 : rx0_q;
        rx1     = frame_start ? roi_x1 : rx1_q;
        ry0     = frame_start ? roi_y0 : ry0_q;
        ry1     = frame_start ? roi_y1 : ry1_q;
        in_roi  = (cur_x >= rx0) && (cur_x <= rx1) && (cur_y >= ry0) && (cur_y <= ry1);
        x_nxt   = (cur_x == X_LAST) ? '0 : cur_x + XW'(1);
        y_nxt   = cur_y;
        if (cur_x == X_LAST && cur_y != Y_LAST) y_nxt = cur_y + YW'(1);
        idx_nxt = (cur_idx == IDX_MAX) ? cur_idx : cur_idx + IW'(1);
        eop_err = beat_eop && (cur_idx != LAST_IDX);
    end

    // One extra bit keeps comp_j + margin from wrapping.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            comp[k] = pix_data[PIX_W-1-k*COMP_W -: COMP_W];
        end
        for (int k = 0; k < NUM_CH; k++) begin
            hit[k] = in_roi && (comp[k] >= min_level);
            for (int j = 0; j < NUM_CH; j++) begin
                if (j != k && ({1'b0, comp[k]} <= ({1'b0, comp[j]} + {1'b0, margin})))
                    hit[k] = 1'b0;
            end
        end
    end

    always_comb begin
        best_ch  = MW'(NUM_CH);
        best_cnt = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            acc_nxt[k] = (hit_q[k] && acc[k] != CNT_MAX) ? acc[k] + CNT_W'(1) : acc[k];
            if (acc_nxt[k] > best_cnt) begin
                best_cnt = acc_nxt[k];
                best_ch  = MW'(k);
            end
        end
    end

    // The last pixel's hit lands during LATCH, so outputs latch the post-increment counts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q         <= '0;
            y_q         <= '0;
            idx_q       <= '0;
            rx0_q       <= '0;
            rx1_q       <= '0;
            ry0_q       <= '0;
            ry1_q       <= '0;
            hit_q       <= '0;
            eop_err_q   <= 1'b0;
            counts_out  <= '0;
            max_ch      <= '0;
            stats_valid <= 1'b0;
            frame_err   <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
        end else begin
            hit_q       <= take ? hit : '0;
            stats_valid <= (state == LATCH);
            frame_err   <= restart_err || ((state == LATCH) && eop_err_q);
            if (take) begin
                x_q   <= x_nxt;
                y_q   <= y_nxt;
                idx_q <= idx_nxt;
                if (beat_eop) eop_err_q <= eop_err;
            end
            if (frame_start) begin
                rx0_q <= roi_x0;
                rx1_q <= roi_x1;
                ry0_q <= roi_y0;
                ry1_q <= roi_y1;
                for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
            end else begin
                for (int k = 0; k < NUM_CH; k++) acc[k] <= acc_nxt[k];
            end
            if (state == LATCH) begin
                max_ch <= best_ch;
                for (int k = 0; k < NUM_CH; k++) counts_out[k*CNT_W +: CNT_W] <= acc_nxt[k];
            end
        end
    end

endmodule
